// File: rtl/vga_pkg.sv
// Shared VGA constants (640x480@60 defaults), frame-size derivation,
// per-pixel control word and colour-channel replication.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  function automatic int scan_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // Sync/blank/marker bits that ride alongside the memory read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic fs;
    logic ls;
  } ctl_t;

  // MSB-first repetition of a bpc-bit channel across dw bits; the last copy is cut short.
  function automatic logic [31:0] expand_channel(input logic [15:0] ch,
                                                 input int bpc, input int dw);
    logic [31:0] r;
    logic [15:0] s;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < dw) begin
        s = ch >> (bpc - 1 - (i % bpc));
        r = {r[30:0], s[0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_scan_engine_if.sv
// Video-memory read port between the scan engine (master) and the framebuffer (slave).
interface vga_scan_engine_if #(
  parameter int ADDR_WIDTH       = 17,
  parameter int BITS_PER_CHANNEL = 1
) ();
  logic [ADDR_WIDTH-1:0]         memory_address;
  logic                          mem_rd_en;
  logic [3*BITS_PER_CHANNEL-1:0] pixel_colour;

  modport master (output memory_address, output mem_rd_en, input pixel_colour);
  modport slave  (input memory_address, input mem_rd_en, output pixel_colour);
endinterface

// File: rtl/vga_timing_gen.sv
// Raster h/v counters with sync levels, visible flag and wrap strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  localparam int H_TOTAL = scan_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL = scan_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          visible,
  output logic          v_active,
  output logic          hs_lvl,
  output logic          vs_lvl,
  output logic          h_wrap,
  output logic          v_wrap
);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic          HS_ON  = 1'(HS_POL);
  localparam logic          VS_ON  = 1'(VS_POL);

  assign h_wrap   = (h == H_LAST);
  assign v_wrap   = h_wrap && (v == V_LAST);
  assign v_active = (v < V_ACT);
  assign visible  = (h < H_ACT) && v_active;
  assign hs_lvl   = (h >= HS_BEG && h <= HS_END) ? HS_ON : ~HS_ON;
  assign vs_lvl   = (v >= VS_BEG && v <= VS_END) ? VS_ON : ~VS_ON;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h_wrap) begin
      h <= '0;
      v <= v_wrap ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

endmodule

// File: rtl/vga_scan_engine.sv
// VGA scan controller: scaled framebuffer addressing, latency-matched sync/blank,
// colour expansion to DAC width. Optional bar pattern under VGA_TEST_PATTERN_EN.
module vga_scan_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE         = VGA_H_ACTIVE,
  parameter int H_FRONT          = VGA_H_FRONT,
  parameter int H_SYNC           = VGA_H_SYNC,
  parameter int H_BACK           = VGA_H_BACK,
  parameter int V_ACTIVE         = VGA_V_ACTIVE,
  parameter int V_FRONT          = VGA_V_FRONT,
  parameter int V_SYNC           = VGA_V_SYNC,
  parameter int V_BACK           = VGA_V_BACK,
  parameter int HS_POL           = 0,
  parameter int VS_POL           = 0,
  parameter int SCALE_LOG2       = 1,
  parameter int BITS_PER_CHANNEL = 1,
  parameter int DAC_WIDTH        = 10,
  parameter int MEM_LATENCY      = 1,
  parameter int ADDR_WIDTH       = 17
) (
  input  logic                 vga_clock,
  input  logic                 reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_mode,
`endif
  vga_scan_engine_if.master    mem,
  output logic [DAC_WIDTH-1:0] VGA_R,
  output logic [DAC_WIDTH-1:0] VGA_G,
  output logic [DAC_WIDTH-1:0] VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 VGA_BLANK,
  output logic                 VGA_SYNC,
  output logic                 frame_start,
  output logic                 line_start
);

  localparam int HW  = $clog2(scan_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK));
  localparam int VW  = $clog2(scan_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK));
  localparam int SW  = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam int BPC = BITS_PER_CHANNEL;
  localparam logic [SW-1:0]         S_MAX  = SW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_WIDTH-1:0] H_DOTS = ADDR_WIDTH'(H_ACTIVE >> SCALE_LOG2);
  localparam logic                  HS_ON  = 1'(HS_POL);
  localparam logic                  VS_ON  = 1'(VS_POL);
  localparam ctl_t CTL_IDLE = '{hs: ~HS_ON, vs: ~VS_ON, blank: 1'b0, fs: 1'b0, ls: 1'b0};

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          visible, v_active, hs_lvl, vs_lvl, h_wrap, v_wrap;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(vga_clock), .rst(reset), .h(h), .v(v), .visible(visible),
    .v_active(v_active), .hs_lvl(hs_lvl), .vs_lvl(vs_lvl),
    .h_wrap(h_wrap), .v_wrap(v_wrap)
  );

  // Dot counters run in step with h/v so the address register lines up with the raster.
  logic [SW-1:0]         sx, sy;
  logic [ADDR_WIDTH-1:0] x_dot, line_base;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      sx        <= '0;
      sy        <= '0;
      x_dot     <= '0;
      line_base <= '0;
    end else if (h_wrap) begin
      sx    <= '0;
      x_dot <= '0;
      if (v_wrap) begin
        sy        <= '0;
        line_base <= '0;
      end else if (v_active) begin
        if (sy == S_MAX) begin
          sy        <= '0;
          line_base <= line_base + H_DOTS;
        end else begin
          sy <= sy + 1'b1;
        end
      end
    end else if (visible) begin
      if (sx == S_MAX) begin
        sx    <= '0;
        x_dot <= x_dot + 1'b1;
      end else begin
        sx <= sx + 1'b1;
      end
    end
  end

  ctl_t                   ctl_now, ctl_out;
  ctl_t [MEM_LATENCY:0]   ctl_pipe;

  assign ctl_now = '{hs: hs_lvl, vs: vs_lvl, blank: visible,
                     fs: visible && h == '0 && v == '0,
                     ls: visible && h == '0};
  assign ctl_out = ctl_pipe[MEM_LATENCY];

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      mem.memory_address <= '0;
      mem.mem_rd_en      <= 1'b0;
      ctl_pipe           <= {(MEM_LATENCY+1){CTL_IDLE}};
    end else begin
      mem.mem_rd_en <= visible;
      if (visible) mem.memory_address <= line_base + x_dot;
      ctl_pipe <= {ctl_pipe[MEM_LATENCY-1:0], ctl_now};
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [MEM_LATENCY:0][2:0] bar_pipe;
  logic [2:0]                bar_now;

  assign bar_now = 3'(32'(h) / BAR_W);

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) bar_pipe <= '0;
    else       bar_pipe <= {bar_pipe[MEM_LATENCY-1:0], bar_now};
  end
`endif

  logic [31:0]          exp_r, exp_g, exp_b;
  logic [DAC_WIDTH-1:0] col_r, col_g, col_b;

  always_comb begin
    exp_r = expand_channel(16'(mem.pixel_colour[3*BPC-1 -: BPC]), BPC, DAC_WIDTH);
    exp_g = expand_channel(16'(mem.pixel_colour[2*BPC-1 -: BPC]), BPC, DAC_WIDTH);
    exp_b = expand_channel(16'(mem.pixel_colour[BPC-1 -: BPC]), BPC, DAC_WIDTH);
    col_r = exp_r[DAC_WIDTH-1:0];
    col_g = exp_g[DAC_WIDTH-1:0];
    col_b = exp_b[DAC_WIDTH-1:0];
`ifdef VGA_TEST_PATTERN_EN
    if (test_mode) begin
      col_r = {DAC_WIDTH{bar_pipe[MEM_LATENCY][2]}};
      col_g = {DAC_WIDTH{bar_pipe[MEM_LATENCY][1]}};
      col_b = {DAC_WIDTH{bar_pipe[MEM_LATENCY][0]}};
    end
`endif
    if (!ctl_out.blank) begin
      col_r = '0;
      col_g = '0;
      col_b = '0;
    end
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= ~HS_ON;
      VGA_VS      <= ~VS_ON;
      VGA_BLANK   <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      VGA_R       <= col_r;
      VGA_G       <= col_g;
      VGA_B       <= col_b;
      VGA_HS      <= ctl_out.hs;
      VGA_VS      <= ctl_out.vs;
      VGA_BLANK   <= ctl_out.blank;
      frame_start <= ctl_out.fs;
      line_start  <= ctl_out.ls;
    end
  end

  assign VGA_SYNC = 1'b1;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine on a reduced 24x12 raster, scale 2, 2-bit channels, latency 3.
module tb_vga_scan_engine;

  localparam int N = 700;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_scan_engine_if #(.ADDR_WIDTH(8), .BITS_PER_CHANNEL(2)) mem_bus ();

  logic [9:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_blank, vga_sync, frame_start, line_start;
`ifdef VGA_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  vga_scan_engine #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(0), .VS_POL(0), .SCALE_LOG2(1), .BITS_PER_CHANNEL(2),
    .DAC_WIDTH(10), .MEM_LATENCY(3), .ADDR_WIDTH(8)
  ) dut (
    .vga_clock(clk),
    .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .mem(mem_bus),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK(vga_blank), .VGA_SYNC(vga_sync),
    .frame_start(frame_start), .line_start(line_start)
  );

  // Memory model: 3-clock read latency; address 0 -> 10_01_11, other dots -> 01_10_00, idle -> all ones.
  logic [7:0] a1 = '0, a2 = '0, a3 = '0;
  logic       e1 = 1'b0, e2 = 1'b0, e3 = 1'b0;
  always @(posedge clk) begin
    a1 <= mem_bus.memory_address; a2 <= a1; a3 <= a2;
    e1 <= mem_bus.mem_rd_en;      e2 <= e1; e3 <= e2;
  end
  assign mem_bus.pixel_colour = !e3 ? 6'b111111 : ((a3 == 8'd0) ? 6'b100111 : 6'b011000);

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] s_addr [1:N];
  logic [31:0] s_rden [1:N];
  logic [31:0] s_hs [1:N];
  logic [31:0] s_vs [1:N];
  logic [31:0] s_blank [1:N];
  logic [31:0] s_fs [1:N];
  logic [31:0] s_ls [1:N];
  logic [31:0] s_r [1:N];
  logic [31:0] s_g [1:N];
  logic [31:0] s_b [1:N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Sample k is taken on the falling edge after the k-th rising edge since reset release.
  task automatic record(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      s_addr[k]  = 32'(mem_bus.memory_address);
      s_rden[k]  = 32'(mem_bus.mem_rd_en);
      s_hs[k]    = 32'(vga_hs);
      s_vs[k]    = 32'(vga_vs);
      s_blank[k] = 32'(vga_blank);
      s_fs[k]    = 32'(frame_start);
      s_ls[k]    = 32'(line_start);
      s_r[k]     = 32'(vga_r);
      s_g[k]     = 32'(vga_g);
      s_b[k]     = 32'(vga_b);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hs"},    32'(vga_hs), 32'd1);
    check({tag, "_vs"},    32'(vga_vs), 32'd1);
    check({tag, "_blank"}, 32'(vga_blank), 32'd0);
    check({tag, "_r"},     32'(vga_r), 32'd0);
    check({tag, "_b"},     32'(vga_b), 32'd0);
    check({tag, "_rden"},  32'(mem_bus.mem_rd_en), 32'd0);
    check({tag, "_addr"},  32'(mem_bus.memory_address), 32'd0);
    check({tag, "_fs"},    32'(frame_start), 32'd0);
    check({tag, "_ls"},    32'(line_start), 32'd0);
  endtask

  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    check("vga_sync", 32'(vga_sync), 32'd1);
    reset = 1'b0;
    record(600);

    // Line 0 addresses: each dot twice, then held with rd_en low in h-blank.
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("l0_addr_%0d", k), s_addr[k], 32'((k - 1) >> 1));
      check($sformatf("l0_rden_%0d", k), s_rden[k], 32'd1);
    end
    check("hblank_rden", s_rden[17], 32'd0);
    check("hblank_addr_hold", s_addr[17], 32'd7);
    check("hblank_rden_end", s_rden[24], 32'd0);
    check("l1_start", s_addr[25], 32'd0);
    check("l1_addr3", s_addr[28], 32'd1);
    check("l2_start", s_addr[49], 32'd8);
    check("l3_start", s_addr[73], 32'd8);
    check("l4_start", s_addr[97], 32'd16);
    check("last_addr", s_addr[184], 32'd31);
    check("vblank_rden", s_rden[250], 32'd0);
    check("vblank_addr_hold", s_addr[250], 32'd31);
    check("f2_addr0", s_addr[289], 32'd0);
    check("f2_rden0", s_rden[289], 32'd1);
    check("f2_addr2", s_addr[291], 32'd1);
    check("f2_l2_start", s_addr[337], 32'd8);

    // Address issued at sample 1 reaches the DAC at sample 5.
    check("blank_pre", s_blank[4], 32'd0);
    check("r_pre", s_r[4], 32'd0);
    check("blank_first", s_blank[5], 32'd1);
    check("r_first", s_r[5], 32'h2AA);
    check("g_first", s_g[5], 32'h155);
    check("b_first", s_b[5], 32'h3FF);
    check("r_dot0_rep", s_r[6], 32'h2AA);
    check("r_dot1", s_r[7], 32'h155);
    check("g_dot1", s_g[7], 32'h2AA);
    check("b_dot1", s_b[7], 32'd0);
    check("last_vis_blank", s_blank[20], 32'd1);
    check("hblank_blank", s_blank[21], 32'd0);
    check("hblank_r_zero", s_r[21], 32'd0);
    check("hblank_b_zero", s_b[21], 32'd0);

    check("fs_first", s_fs[5], 32'd1);
    check("fs_next", s_fs[6], 32'd0);
    check("fs_f2", s_fs[293], 32'd1);
    cnt = 0;
    for (int k = 1; k <= 600; k++) cnt += int'(s_fs[k]);
    check("fs_count", 32'(cnt), 32'd3);
    check("ls_l0", s_ls[5], 32'd1);
    check("ls_l0_next", s_ls[6], 32'd0);
    check("ls_l1", s_ls[29], 32'd1);
    check("ls_vblank", s_ls[197], 32'd0);
    cnt = 0;
    for (int k = 5; k <= 292; k++) cnt += int'(s_ls[k]);
    check("ls_count", 32'(cnt), 32'd8);

    check("hs_before", s_hs[22], 32'd1);
    check("hs_fall", s_hs[23], 32'd0);
    check("hs_last", s_hs[25], 32'd0);
    check("hs_after", s_hs[26], 32'd1);
    cnt = 0;
    for (int k = 5; k <= 292; k++) cnt += int'(s_hs[k] == 32'd0);
    check("hs_low_count", 32'(cnt), 32'd36);
    check("vs_before", s_vs[220], 32'd1);
    check("vs_fall", s_vs[221], 32'd0);
    check("vs_last", s_vs[268], 32'd0);
    check("vs_after", s_vs[269], 32'd1);
    cnt = 0;
    for (int k = 5; k <= 292; k++) cnt += int'(s_vs[k] == 32'd0);
    check("vs_low_count", 32'(cnt), 32'd48);

    // Mid-frame reset while a visible pixel is on the DAC.
    repeat (110) @(negedge clk);
    check("pre_rst_blank", 32'(vga_blank), 32'd1);
    check("pre_rst_rden", 32'(mem_bus.mem_rd_en), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_values("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    record(300);
    check("rst2_addr1", s_addr[1], 32'd0);
    check("rst2_rden1", s_rden[1], 32'd1);
    check("rst2_addr3", s_addr[3], 32'd1);
    check("rst2_fs", s_fs[5], 32'd1);
    check("rst2_hs_before", s_hs[22], 32'd1);
    check("rst2_hs_fall", s_hs[23], 32'd0);
    check("rst2_vs_before", s_vs[220], 32'd1);
    check("rst2_vs_fall", s_vs[221], 32'd0);
    check("rst2_l2_start", s_addr[49], 32'd8);

`ifdef VGA_TEST_PATTERN_EN
    reset = 1'b1;
    test_mode = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    record(100);
    check("tp_c0_r", s_r[5], 32'd0);
    check("tp_c0_b", s_b[5], 32'd0);
    check("tp_c2_b", s_b[7], 32'h3FF);
    check("tp_c2_g", s_g[7], 32'd0);
    check("tp_c4_g", s_g[9], 32'h3FF);
    check("tp_c4_b", s_b[9], 32'd0);
    check("tp_c15_r", s_r[20], 32'h3FF);
    check("tp_c15_g", s_g[20], 32'h3FF);
    check("tp_c15_b", s_b[20], 32'h3FF);
    check("tp_hblank_r", s_r[21], 32'd0);
    check("tp_addr", s_addr[3], 32'd1);
    check("tp_l2_start", s_addr[49], 32'd8);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
- Parametrised next-generation VGA scan controller. Generates programmable sync/blank timing and linear video-memory read addresses for an integer-scaled framebuffer.
- Aligns sync/blank to a configurable memory read latency and expands N-bit colour channels to the DAC width.
- Sits between video memory (read port) and the ADV-style VGA DAC; clocked by the pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, horizontal sync active level
- VS_POL, 0, vertical sync active level
- SCALE_LOG2, 1, each framebuffer dot is 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels (0..3)
- BITS_PER_CHANNEL, 1, colour bits per R/G/B channel
- DAC_WIDTH, 10, DAC bits per channel
- MEM_LATENCY, 1, clocks from memory_address to valid pixel_colour (>=1)
- ADDR_WIDTH, 17, memory address width

Ports:
- vga_clock, in, 1, pixel clock
- reset, in, 1, asynchronous active-high reset
- pixel_colour, in, 3*BITS_PER_CHANNEL, {R,G,B} read data, valid MEM_LATENCY clocks after address
- memory_address, out, ADDR_WIDTH, linear dot address
- mem_rd_en, out, 1, address valid (visible region)
- VGA_R / VGA_G / VGA_B, out, DAC_WIDTH each, DAC colour
- VGA_HS / VGA_VS, out, 1 each, sync at HS_POL/VS_POL active level
- VGA_BLANK, out, 1, 1 = visible pixel, 0 = blanked
- VGA_SYNC, out, 1, tied 1
- frame_start, out, 1, one-cycle pulse coincident with DAC output of pixel (0,0)
- line_start, out, 1, one-cycle pulse coincident with DAC output of column 0 of every visible line

Behaviour:
- One clock; reset is asynchronous and active-high, ports vga_clock and reset.
- Counters:
  - h counts 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK.
  - v increments when h wraps and counts 0..V_TOTAL-1.
- Sync windows:
  - HS active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
  - VS uses the same rule on v.
- Visible region: h<H_ACTIVE && v<V_ACTIVE.
- Addressing (no multiplier):
  - Sub-counters sx and sy count 0..2^SCALE_LOG2-1.
  - x_dot increments on sx wrap and resets at line end.
  - line_base resets to 0 at frame start.
  - line_base += H_DOTS (H_ACTIVE>>SCALE_LOG2) when sy wraps at the end of a visible line.
  - memory_address = line_base + x_dot.
  - memory_address and mem_rd_en are registered and issued at cycle n for pixel (h,v).
  - Outside the visible region: mem_rd_en=0 and memory_address holds its value.
- Latency:
  - Colour expansion is registered, so VGA_R/G/B appear at n+MEM_LATENCY+1.
  - HS, VS, BLANK, frame_start and line_start are delayed through a shift register to the same cycle.
  - When BLANK=0, colour outputs are forced to 0.
- Colour expansion: replicate channel bits MSB-first across DAC_WIDTH, truncating the final partial copy.
- Reset values:
  - Counters, line_base and memory_address = 0; mem_rd_en=0.
  - VGA_R/G/B=0, VGA_BLANK=0.
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL.
  - frame_start=0, line_start=0.
  - Delay pipeline cleared to the inactive values above.
- Reset mid-frame: outputs take reset values immediately (asynchronously). After release, scanning restarts at (0,0) with address 0.
- Simultaneous h and v wrap: v, sy and line_base all clear together, with no extra increment.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1, pixel_colour is replaced at the expansion stage by 8 vertical bars of width H_ACTIVE/8 (aligned to delayed h).
  - Bar index b (0..7) drives R=b[2], G=b[1], B=b[0], with each channel at full scale (all DAC bits = the bit).
  - Timing and addressing are unchanged.
- Undefined: no port and no logic.

Decomposition:
- Package vga_pkg holds:
  - the 640x480@60 timing constants;
  - the H_TOTAL/V_TOTAL derivation;
  - the colour-replication function.
- Sub-module vga_timing_gen produces h, v, sync, visible, line/frame wrap strobes.
- vga_scan_engine adds addressing, the delay pipeline and colour expansion.

Test Plan:
- Defaults, release reset:
  - Each line is 800 clocks; VGA_HS is low for exactly 96 clocks, with its falling edge 656+2 clocks after line start.
  - VS is low for 1600 clocks per 420000-clock frame.
  - frame_start occurs once per frame.
- SCALE_LOG2=1 addressing:
  - Line 0 issues 0,0,1,1,...,319,319.
  - Line 1 repeats line 0.
  - Line 2 starts at 320.
  - Last address of line 479 is 76799.
  - mem_rd_en=0 for h>=640.
- SCALE_LOG2=2, ADDR_WIDTH=15: line 4 starts at 160; final address 19199.
- BITS_PER_CHANNEL=2, pixel_colour=6'b10_01_11:
  - VGA_R=10'b1010101010, VGA_G=10'b0101010101, VGA_B=10'b1111111111.
  - Colour appears MEM_LATENCY+1 clocks after the address.
  - With MEM_LATENCY=3, VGA_BLANK rises on the same clock as the first valid colour.
- Reset asserted at h=300,v=200:
  - Outputs return to reset values without waiting for a clock edge.
  - After release, the first address is 0 and VGA_HS/VGA_VS line/frame timing restarts from h=0,v=0.
- VGA_TEST_PATTERN_EN, test_mode=1:
  - Columns 0..79 are black, 80..159 blue, 160..239 green, ..., 560..639 white (all DAC bits 1).
  - memory_address sequence is unchanged.
